// File: rtl/instr_fetch.sv
// Instruction-supply unit: word-addressed program store streamed to the core
// at one instruction per cycle, with stall, branch redirect and halt handling.
module instr_fetch #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [31:0]       pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    localparam logic [31:0] EBREAK      = 32'h0010_0073;
    localparam logic [31:0] STORE_BYTES = 32'(DEPTH) << 2;

    logic [31:0]       mem [DEPTH];
    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       rd_data;
    logic [31:0]       pc_inc;
    logic              wr_en;
    logic              redir_bad;
    logic              run_stop;

    assign wr_en     = load_en && (state_q != ST_RUN);
    assign pc_inc    = pc_q + 32'd4;
    assign redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= STORE_BYTES);
    assign run_stop  = (instr_q == EBREAK) || (pc_inc == STORE_BYTES);

    // Single read port; the address is chosen by whichever fetch the edge will commit.
    always_comb begin
        rd_idx = pc_inc[ADDR_W+1:2];
        if (state_q != ST_RUN) begin
            rd_idx = RESET_PC[ADDR_W+1:2];
        end else if (redirect) begin
            rd_idx = redirect_pc[ADDR_W+1:2];
        end
    end

    // Write-first bypass: a same-cycle load to the fetched index is seen by the fetch.
    assign rd_data = (wr_en && (load_addr == rd_idx)) ? load_data : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    if (redir_bad) begin
                        state_d = ST_HALT;
                    end
                end else if (!stall && run_stop) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    instr_d = rd_data;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (!redir_bad) begin
                        instr_d = rd_data;
                    end
                end else if (!stall && !run_stop) begin
                    pc_d    = pc_inc;
                    instr_d = rd_data;
                end
            end
            default: begin
                pc_d    = pc_q;
                instr_d = instr_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        instr_valid = (state_q == ST_RUN);
        halted      = (state_q == ST_HALT);
        instr       = instr_q;
        pc          = pc_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_instr_fetch;

    localparam int DEPTH = 64;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [DEPTH];
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] prog [4];

    instr_fetch #(.DEPTH(64), .ADDR_W(6), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = 32'h0;
        m_instr = 32'h0;
    endtask

    // One clock edge of the fetch unit, stated directly from its rules.
    task automatic model_edge();
        if (load_en && m_mode != M_RUN) m_mem[load_addr] = load_data;
        if (m_mode != M_RUN) begin
            if (start) begin
                m_mode  = M_RUN;
                m_pc    = 32'h0;
                m_instr = m_mem[0];
            end
        end else if (redirect) begin
            m_pc = redirect_pc;
            if (redirect_pc % 4 != 0 || redirect_pc >= DEPTH * 4) m_mode = M_HALT;
            else m_instr = m_mem[redirect_pc / 4];
        end else if (stall) begin
            // hold
        end else if (m_instr == EBREAK || m_pc + 4 == DEPTH * 4) begin
            m_mode = M_HALT;
        end else begin
            m_pc    = m_pc + 4;
            m_instr = m_mem[m_pc / 4];
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".instr"},  instr, m_instr);
        chk({tag, ".pc"},     pc, m_pc);
        chk({tag, ".valid"},  32'(instr_valid), 32'(m_mode == M_RUN));
        chk({tag, ".halted"}, 32'(halted), 32'(m_mode == M_HALT));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic run_to_halt(input string tag);
        for (int i = 0; i < 80 && m_mode != M_HALT; i++) step(tag);
        chk({tag, ".reached_halt"}, 32'(halted), 32'd1);
    endtask

    initial begin
        prog[0] = 32'h06300F13;
        prog[1] = 32'h01E02023;
        prog[2] = 32'h00002F83;
        prog[3] = EBREAK;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // Load the program while idle
        for (int i = 0; i < 4; i++) begin
            load_en = 1'b1; load_addr = 6'(i); load_data = prog[i];
            step("load");
        end
        load_en = 1'b0;

        // Straight-line run ending on ebreak
        start = 1'b1; step("start");
        start = 1'b0;
        chk("first_instr", instr, 32'h06300F13);
        chk("first_pc", pc, 32'h0);
        step("run1"); step("run2"); step("run3");
        chk("ebreak_fetched", instr, EBREAK);
        step("ebreak_halt");
        chk("ebreak_pc", pc, 32'd12);
        chk("ebreak_halted", 32'(halted), 32'd1);

        // Stall holds the pc=4 instruction for three cycles
        start = 1'b1; step("st_start");
        start = 1'b0; step("st_pc4");
        stall = 1'b1; step("stall1"); step("stall2");
        stall = 1'b0; step("unstall");
        chk("after_stall_pc", pc, 32'd8);
        step("st_pc12"); step("st_halt");

        // Redirect beats stall
        start = 1'b1; step("rd_start");
        start = 1'b0; step("rd_pc4");
        redirect = 1'b1; redirect_pc = 32'h0; stall = 1'b1; step("redir_stall");
        chk("redir_pc", pc, 32'h0);
        chk("redir_instr", instr, 32'h06300F13);
        redirect = 1'b0; stall = 1'b0;

        // Misaligned and out-of-range redirect targets halt
        step("mis_pc4");
        redirect = 1'b1; redirect_pc = 32'h6; step("misaligned");
        chk("misaligned_halted", 32'(halted), 32'd1);
        redirect_pc = 32'h0; step("redir_in_halt");
        redirect = 1'b0;
        start = 1'b1; step("oor_start");
        start = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h100; step("out_of_range");
        chk("oor_valid", 32'(instr_valid), 32'd0);
        redirect = 1'b0;

        // Ebreak halt deferred by stall
        start = 1'b1; step("def_start");
        start = 1'b0; step("def1"); step("def2"); step("def3");
        stall = 1'b1; step("def_stall1"); step("def_stall2");
        stall = 1'b0; step("def_release");

        // Write-first on start, then loads during RUN are dropped
        load_en = 1'b1; load_addr = 6'd0; load_data = 32'h00500093; start = 1'b1;
        step("write_first");
        chk("write_first_instr", instr, 32'h00500093);
        start = 1'b0; load_addr = 6'd1; load_data = 32'hDEADBEEF;
        step("load_in_run");
        chk("load_ignored", instr, 32'h01E02023);
        load_en = 1'b0;
        run_to_halt("wf_run");
        load_en = 1'b1; load_addr = 6'd0; load_data = 32'h06300F13; step("restore");
        load_en = 1'b0;

        // Asynchronous reset mid-run, then rerun without reload
        start = 1'b1; step("ar_start");
        start = 1'b0; step("ar_pc4"); step("ar_pc8");
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; step("rerun");
        start = 1'b0;
        chk("rerun_instr", instr, 32'h06300F13);
        run_to_halt("rerun_run");

        // Full store of nops runs off the end without wrapping
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1'b1; load_addr = 6'(i); load_data = NOP;
            step("nop_fill");
        end
        load_en = 1'b0;
        start = 1'b1; step("nop_start");
        start = 1'b0;
        run_to_halt("nop_run");
        chk("nop_end_pc", pc, 32'd252);

        // Random program and random control traffic
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1'b1; load_addr = 6'(i);
            load_data = ($urandom_range(0, 15) == 0) ? EBREAK : $urandom;
            step("rnd_fill");
        end
        for (int c = 0; c < 600; c++) begin
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) < 7) redirect_pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else redirect_pc = $urandom_range(0, 511);
            start     = (m_mode == M_RUN) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
            load_en   = ($urandom_range(0, 4) == 0);
            load_addr = 6'($urandom);
            load_data = ($urandom_range(0, 7) == 0) ? EBREAK : $urandom;
            step("random");
        end
        stall = 1'b0; redirect = 1'b0; start = 1'b0; load_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
